// File: rtl/boot_loader.sv
// Program loader: pre-fills instruction memory with a NOP pattern, streams program bytes
// from a valid/ready source into consecutive addresses, then releases the core from reset.
module boot_loader #(
   parameter int                   DATA_BITS = 8,
   parameter int                   ADDR_BITS = 8,
   parameter logic [3:0]           NOP_OP    = 4'h0,
   parameter logic [DATA_BITS-1:0] FILL_EVEN = DATA_BITS'({NOP_OP, 4'b0000}),
   parameter logic [DATA_BITS-1:0] FILL_ODD  = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [DATA_BITS-1:0] mem_wdata,
   output logic                 core_reset,
   output logic                 done,
   output logic                 overflow,
   output logic [ADDR_BITS:0]   bytes_loaded
);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_LOAD, S_RELEASE, S_DONE} state_t;

   localparam logic [ADDR_BITS:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

   state_t                 r_state,        w_state_nxt;
   logic                   r_mem_we,       w_mem_we_nxt;
   logic [ADDR_BITS-1:0]   r_mem_addr,     w_mem_addr_nxt;
   logic [DATA_BITS-1:0]   r_mem_wdata,    w_mem_wdata_nxt;
   logic                   r_core_reset,   w_core_reset_nxt;
   logic                   r_done,         w_done_nxt;
   logic                   r_overflow,     w_overflow_nxt;
   logic [ADDR_BITS:0]     r_bytes_loaded, w_bytes_loaded_nxt;
   logic [ADDR_BITS-1:0]   w_addr_inc;
   logic [ADDR_BITS:0]     w_bytes_inc;

   assign w_addr_inc  = r_mem_addr + ADDR_BITS'(1);
   // bytes_loaded must saturate at DEPTH rather than wrap
   assign w_bytes_inc = (r_bytes_loaded == DEPTH) ? r_bytes_loaded
                                                  : r_bytes_loaded + (ADDR_BITS+1)'(1);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      w_state_nxt        = r_state;
      w_mem_we_nxt       = 1'b0;
      w_mem_addr_nxt     = r_mem_addr;
      w_mem_wdata_nxt    = r_mem_wdata;
      w_core_reset_nxt   = r_core_reset;
      w_done_nxt         = r_done;
      w_overflow_nxt     = r_overflow;
      w_bytes_loaded_nxt = r_bytes_loaded;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt      = S_FILL;
               w_mem_we_nxt     = 1'b1;
               w_mem_addr_nxt   = '0;
               w_mem_wdata_nxt  = FILL_EVEN;
               w_core_reset_nxt = 1'b1;
               w_done_nxt       = 1'b0;
               w_overflow_nxt   = 1'b0;
            end
         end
         S_FILL: begin
            // mem_addr doubles as the fill counter: it holds the write currently on the port
            if (r_mem_addr == '1) begin
               w_state_nxt        = S_LOAD;
               w_mem_addr_nxt     = '0;
               w_bytes_loaded_nxt = '0;
            end else begin
               w_mem_we_nxt    = 1'b1;
               w_mem_addr_nxt  = w_addr_inc;
               w_mem_wdata_nxt = w_addr_inc[0] ? FILL_ODD : FILL_EVEN;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               w_mem_we_nxt       = 1'b1;
               w_mem_addr_nxt     = r_bytes_loaded[ADDR_BITS-1:0];
               w_mem_wdata_nxt    = in_data;
               w_bytes_loaded_nxt = w_bytes_inc;
               if (in_last) begin
                  w_state_nxt = S_RELEASE;
               end else if (r_bytes_loaded[ADDR_BITS-1:0] == '1) begin
                  w_state_nxt    = S_RELEASE;
                  w_overflow_nxt = 1'b1;
               end
            end
         end
         S_RELEASE: begin
            w_state_nxt      = S_DONE;
            w_core_reset_nxt = 1'b0;
            w_done_nxt       = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= '0;
         r_core_reset   <= 1'b1;
         r_done         <= 1'b0;
         r_overflow     <= 1'b0;
         r_bytes_loaded <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_mem_we       <= w_mem_we_nxt;
         r_mem_addr     <= w_mem_addr_nxt;
         r_mem_wdata    <= w_mem_wdata_nxt;
         r_core_reset   <= w_core_reset_nxt;
         r_done         <= w_done_nxt;
         r_overflow     <= w_overflow_nxt;
         r_bytes_loaded <= w_bytes_loaded_nxt;
      end
   end

   assign in_ready     = (r_state == S_LOAD);
   assign mem_we       = r_mem_we;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign core_reset   = r_core_reset;
   assign done         = r_done;
   assign overflow     = r_overflow;
   assign bytes_loaded = r_bytes_loaded;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: random streams checked against a simple
// image/timing model of fill, load, overflow, release, reset and reload.
module tb_boot_loader;

   localparam int         DB     = 8;
   localparam int         AB     = 8;
   localparam int         DEPTH  = 1 << AB;
   localparam logic [3:0] NOP_OP = 4'hA;
   localparam logic [7:0] FILL_E = {NOP_OP, 4'h0};
   localparam logic [7:0] FILL_O = 8'h00;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [DB-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          in_ready, mem_we, core_reset, done, overflow;
   logic [AB-1:0] mem_addr;
   logic [DB-1:0] mem_wdata;
   logic [AB:0]   bytes_loaded;

   boot_loader #(.DATA_BITS(DB), .ADDR_BITS(AB), .NOP_OP(NOP_OP)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .core_reset(core_reset), .done(done), .overflow(overflow), .bytes_loaded(bytes_loaded)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // instruction memory sink, written exactly as exec_unit's write port would be
   logic [DB-1:0] sink [DEPTH];
   always @(posedge clk) if (mem_we) sink[mem_addr] <= mem_wdata;

   logic [DB-1:0] tx_q[$];
   logic [DB-1:0] prog[14] = '{8'hA0, 8'h00, 8'h10, 8'h01, 8'h11, 8'h10, 8'h30, 8'h01,
                               8'h41, 8'h00, 8'h30, 8'h01, 8'h70, 8'h04};
   int t_e;
   int n_checks = 0;
   int n_errors = 0;

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 ||
          core_reset !== 1'b1 || mem_addr !== '0 || mem_wdata !== '0 || bytes_loaded !== '0) begin
         n_errors++;
         $display("FAIL reset_values: rdy=%b we=%b done=%b ovf=%b crst=%b addr=%h wd=%h bl=%0d, want 0 0 0 0 1 0 0 0",
                  in_ready, mem_we, done, overflow, core_reset, mem_addr, mem_wdata, bytes_loaded);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (core_reset !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
         n_errors++;
         $display("FAIL idle_hold: crst=%b rdy=%b we=%b, want 1 0 0", core_reset, in_ready, mem_we);
      end
   endtask

   // Pulse start, check every fill write, and that in_ready rises DEPTH cycles after start.
   task automatic do_fill();
      logic [DB-1:0] exp_d;
      in_valid = 1'b0;
      in_last  = 1'b0;
      start    = 1'b1;
      @(negedge clk);
      t_e = cyc;
      for (int i = 0; i < DEPTH; i++) begin
         exp_d = i[0] ? FILL_O : FILL_E;
         n_checks++;
         if (mem_we !== 1'b1 || mem_addr !== AB'(i) || mem_wdata !== exp_d || in_ready !== 1'b0 ||
             core_reset !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL fill_write[%0d]: we=%b addr=%h wd=%h rdy=%b crst=%b done=%b, want 1 %h %h 0 1 0",
                     i, mem_we, mem_addr, mem_wdata, in_ready, core_reset, done, AB'(i), exp_d);
         end
         if (i == 0) begin
            n_checks++;
            if (overflow !== 1'b0) begin
               n_errors++;
               $display("FAIL fill_ovf_clear: overflow=%b, want 0", overflow);
            end
         end
         start = (i == DEPTH / 2);  // must be ignored mid-fill
         @(negedge clk);
      end
      start = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || mem_we !== 1'b0 || bytes_loaded !== '0 || cyc - t_e !== DEPTH) begin
         n_errors++;
         $display("FAIL load_entry: rdy=%b we=%b bl=%0d dt=%0d, want 1 0 0 %0d",
                  in_ready, mem_we, bytes_loaded, cyc - t_e, DEPTH);
      end
   endtask

   // Stream tx_q; entry at the first LOAD cycle. abort_at >= 0 asserts reset after that many bytes.
   task automatic do_stream(input int n, input bit use_last, input int gap, input bit chk_lat,
                            input int abort_at);
      int            idx = 0;
      bit            fin = 1'b0, pv = 1'b0, ovf_exp = 1'b0, v;
      int            pidx = 0;
      logic [DB-1:0] pdat = '0;
      for (int c = 0; c < n * 20 + 100 && !fin; c++) begin
         n_checks++;
         if (pv ? (mem_we !== 1'b1 || mem_addr !== AB'(pidx) || mem_wdata !== pdat) : (mem_we !== 1'b0)) begin
            n_errors++;
            $display("FAIL load_write c=%0d: we=%b addr=%h wd=%h, want we=%b addr=%h wd=%h",
                     c, mem_we, mem_addr, mem_wdata, pv, AB'(pidx), pdat);
         end
         n_checks++;
         if (bytes_loaded !== (AB+1)'(idx)) begin
            n_errors++;
            $display("FAIL bytes_loaded c=%0d: got %0d want %0d", c, bytes_loaded, idx);
         end
         if (abort_at >= 0 && idx == abort_at) begin
            in_valid = 1'b1;
            #2 reset = 1'b0;
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 ||
                core_reset !== 1'b1 || mem_addr !== '0 || mem_wdata !== '0 || bytes_loaded !== '0) begin
               n_errors++;
               $display("FAIL async_reset: rdy=%b we=%b done=%b ovf=%b crst=%b addr=%h wd=%h bl=%0d, want 0 0 0 0 1 0 0 0",
                        in_ready, mem_we, done, overflow, core_reset, mem_addr, mem_wdata, bytes_loaded);
            end
            @(negedge clk);
            reset    = 1'b1;
            in_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (core_reset !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
               n_errors++;
               $display("FAIL post_reset_idle: crst=%b rdy=%b we=%b, want 1 0 0", core_reset, in_ready, mem_we);
            end
            return;
         end
         n_checks++;
         if (in_ready !== 1'b1 || core_reset !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL load_state c=%0d: rdy=%b crst=%b done=%b, want 1 1 0", c, in_ready, core_reset, done);
         end
         v        = ($urandom_range(99) >= gap);
         in_valid = v;
         in_data  = (idx < n) ? tx_q[idx] : DB'($urandom);
         in_last  = use_last && (idx == n - 1);
         pv       = v;
         pidx     = idx;
         pdat     = in_data;
         if (v) begin
            idx++;
            fin     = (use_last && idx == n) || (idx == DEPTH);
            ovf_exp = !(use_last && idx == n) && (idx == DEPTH);
         end
         @(negedge clk);
      end
      if (!fin) begin
         n_checks++;
         n_errors++;
         $display("FAIL stream_timeout: accepted %0d of %0d", idx, n);
         return;
      end
      // RELEASE: keep offering bytes, none may be taken
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_data  = DB'($urandom);
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== AB'(pidx) || mem_wdata !== pdat || in_ready !== 1'b0 ||
          core_reset !== 1'b1 || done !== 1'b0 || overflow !== ovf_exp || bytes_loaded !== (AB+1)'(idx)) begin
         n_errors++;
         $display("FAIL release: we=%b addr=%h wd=%h rdy=%b crst=%b done=%b ovf=%b bl=%0d, want 1 %h %h 0 1 0 %b %0d",
                  mem_we, mem_addr, mem_wdata, in_ready, core_reset, done, overflow, bytes_loaded,
                  AB'(pidx), pdat, ovf_exp, idx);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || core_reset !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0 ||
          overflow !== ovf_exp || bytes_loaded !== (AB+1)'(idx)) begin
         n_errors++;
         $display("FAIL done: done=%b crst=%b rdy=%b we=%b ovf=%b bl=%0d, want 1 0 0 0 %b %0d",
                  done, core_reset, in_ready, mem_we, overflow, bytes_loaded, ovf_exp, idx);
      end
      if (chk_lat) begin
         n_checks++;
         if (cyc - t_e !== DEPTH + idx + 1) begin
            n_errors++;
            $display("FAIL load_latency: got %0d cycles want %0d", cyc - t_e, DEPTH + idx + 1);
         end
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (mem_we !== 1'b0 || done !== 1'b1 || in_ready !== 1'b0 || bytes_loaded !== (AB+1)'(idx)) begin
            n_errors++;
            $display("FAIL done_hold[%0d]: we=%b done=%b rdy=%b bl=%0d, want 0 1 0 %0d",
                     k, mem_we, done, in_ready, bytes_loaded, idx);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic check_image(input int n_img);
      logic [DB-1:0] exp_d;
      for (int a = 0; a < DEPTH; a++) begin
         exp_d = (a < n_img) ? tx_q[a] : (a[0] ? FILL_O : FILL_E);
         n_checks++;
         if (sink[a] !== exp_d) begin
            n_errors++;
            $display("FAIL image[%0d]: got %h want %h", a, sink[a], exp_d);
         end
      end
   endtask

   task automatic load_prog();
      tx_q.delete();
      foreach (prog[i]) tx_q.push_back(prog[i]);
   endtask

   task automatic load_random(input int n);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(DB'($urandom));
   endtask

   task automatic test_fill_then_program();
      do_fill();
      for (int k = 0; k < 4; k++) begin
         start = (k == 1);  // ignored in LOAD
         @(negedge clk);
         n_checks++;
         if (in_ready !== 1'b1 || mem_we !== 1'b0 || bytes_loaded !== '0) begin
            n_errors++;
            $display("FAIL load_idle[%0d]: rdy=%b we=%b bl=%0d, want 1 0 0", k, in_ready, mem_we, bytes_loaded);
         end
      end
      start = 1'b0;
      load_prog();
      do_stream(14, 1'b1, 0, 1'b0, -1);
      check_image(14);
   endtask

   task automatic test_program_timing();
      load_prog();
      do_fill();
      do_stream(14, 1'b1, 0, 1'b1, -1);
      check_image(14);
   endtask

   task automatic test_bubbled();
      load_prog();
      do_fill();
      do_stream(14, 1'b1, 50, 1'b0, -1);
      check_image(14);
   endtask

   task automatic test_overflow();
      load_random(DEPTH + 4);
      do_fill();
      do_stream(DEPTH + 4, 1'b0, 0, 1'b1, -1);
      check_image(DEPTH);
   endtask

   task automatic test_reload();
      load_random(9);
      do_fill();
      do_stream(9, 1'b1, 25, 1'b0, -1);
      check_image(9);
   endtask

   task automatic test_reset_mid_load();
      load_prog();
      do_fill();
      do_stream(14, 1'b1, 0, 1'b0, 5);
      load_random(11);
      do_fill();
      do_stream(11, 1'b1, 0, 1'b1, -1);
      check_image(11);
   endtask

   initial begin
      test_reset();
      test_fill_then_program();
      test_program_timing();
      test_bubbled();
      test_overflow();
      test_reload();
      test_reset_mid_load();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
